// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package adder_arbiter_pkg;

  // Operation sequencing: grant, registered add, then hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int OPCNT_W       = 16;

  // Next requester index after idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_core.sv
// Purely combinational WIDTH-bit adder producing {carry, sum}.
module adder_core
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Zero-extend both operands so the carry lands in the top bit.
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ valid/ready requesters.
// Each accepted request runs IDLE -> EXEC -> RESP; the response is held
// until the granted requester accepts it.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NREQ     = 2,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic                  busy,
  output logic [OPCNT_W-1:0]    op_count
);

  localparam int IDXW = (NREQ > 2) ? 2 : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDXW-1:0]    r_prio;
  logic [IDXW-1:0]    r_gnt;
  logic [IDXW-1:0]    w_sel;
  logic               w_found;
  logic               w_hs;
  logic               w_rsp_hs;
  logic [WIDTH-1:0]   r_x_p0;
  logic [WIDTH-1:0]   r_y_p0;
  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_carry;
  logic [WIDTH-1:0]   r_sum_p1;
  logic               r_carry_p1;
  logic [OPCNT_W-1:0] r_op_count;

  // Clamp to all-ones on carry-out when saturation is enabled.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                               input logic             c);
    if ((SATURATE != 0) && c) return '1;
    return s;
  endfunction

  // Scan requesters starting at prio, wrapping, and pick the first valid one.
  always_comb begin
    int idx;
    idx     = int'(r_prio);
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[idx[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[IDXW-1:0];
      end
      idx = rr_next(idx, NREQ);
    end
  end

  // A grant is only offered from IDLE with ena high; valid is implied by w_found.
  assign w_hs     = (r_state == IDLE) && ena && w_found;
  assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_gnt];

  // One-hot request accept toward the selected requester.
  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_sel] = 1'b1;
  end

  // One-hot response valid toward the granted requester while holding.
  always_comb begin
    rsp_valid = '0;
    if (r_state == RESP) rsp_valid[r_gnt] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: EXEC always lasts one cycle, RESP waits for acceptance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant owner and rotating priority, updated on each accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= '0;
      r_gnt  <= '0;
    end else if (w_hs) begin
      r_gnt  <= w_sel;
      r_prio <= IDXW'(rr_next(int'(w_sel), NREQ));
    end
  end

  // Stage p0: operand capture at the request handshake
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_x_p0 <= req_x[w_sel*WIDTH +: WIDTH];
      r_y_p0 <= req_y[w_sel*WIDTH +: WIDTH];
    end
  end

  adder_core #(
    .WIDTH (WIDTH)
  ) u_adder_core (
    .i_a     (r_x_p0),
    .i_b     (r_y_p0),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  // Stage p1: registered sum/carry, held stable through RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum_p1   <= '0;
      r_carry_p1 <= 1'b0;
    end else if (r_state == EXEC) begin
      r_sum_p1   <= sat_sum(w_add_sum, w_add_carry);
      r_carry_p1 <= w_add_carry;
    end
  end

  // Completed-operation counter, sticking at its maximum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_hs && (r_op_count != '1)) begin
      r_op_count <= r_op_count + OPCNT_W'(1);
    end
  end

  assign rsp_sum   = r_sum_p1;
  assign rsp_carry = r_carry_p1;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_op_count;

endmodule
